// File: rtl/fb_rect_fill_ctrl.sv
// fb_rect_fill_ctrl
// Rectangle fill engine for a single-port framebuffer. A fill command
// writes one colour into every pixel of an inclusive rectangle in raster
// order. Display scan-out owns the memory port whenever it asks for it,
// so the fill simply stalls on those cycles and retries the same pixel.
module fb_rect_fill_ctrl #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x0,
    input  logic [9:0]  cmd_y0,
    input  logic [9:0]  cmd_x1,
    input  logic [9:0]  cmd_y1,
    input  logic [8:0]  cmd_color,
    input  logic        disp_req,
    input  logic [18:0] disp_addr,
    output logic        disp_grant,
    output logic [18:0] mem_addr,
    output logic        mem_we,
    output logic [8:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_FILL  = 2'd1;
    localparam logic [1:0]  ST_DONE  = 2'd2;

    localparam logic [10:0] H_LIM    = 11'(H_RES);
    localparam logic [10:0] V_LIM    = 11'(V_RES);
    localparam logic [18:0] H_STRIDE = 19'(H_RES);

    // Constant-coefficient multiply by the line stride, built from the
    // set bits of H_RES so it maps onto adders rather than a multiplier.
    // For 640 this reduces to (y << 9) + (y << 7).
    function automatic logic [18:0] mul_hres(input logic [9:0] y);
        logic [18:0] acc;
        acc = 19'd0;
        for (int i = 0; i < 19; i++) begin
            if (H_STRIDE[i]) begin
                acc = acc + (19'(y) << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    logic [1:0]  state_q,    state_d;
    logic [9:0]  x0_q,       x0_d;
    logic [9:0]  x1_q,       x1_d;
    logic [9:0]  y1_q,       y1_d;
    logic [8:0]  color_q,    color_d;
    logic [9:0]  cur_x_q,    cur_x_d;
    logic [9:0]  cur_y_q,    cur_y_d;
    logic [18:0] row_base_q, row_base_d;
    logic        err_q,      err_d;

    logic cmd_ready_s;
    logic accept_s;
    logic cmd_bad_s;
    logic write_s;
    logic last_s;

    // Handshake, command validation and per-cycle write qualification.
    always_comb begin
        cmd_ready_s = (state_q == ST_IDLE) && !reset;
        accept_s    = cmd_valid && cmd_ready_s;
        cmd_bad_s   = (cmd_x0 > cmd_x1) || (cmd_y0 > cmd_y1) ||
                      ({1'b0, cmd_x1} >= H_LIM) || ({1'b0, cmd_y1} >= V_LIM);
        write_s     = (state_q == ST_FILL) && !disp_req && !reset;
        last_s      = (cur_x_q == x1_q) && (cur_y_q == y1_q);
    end

    // Next-state logic: command latch, raster walk and completion.
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        color_d    = color_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        row_base_d = row_base_q;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && cmd_bad_s) begin
                    err_d = 1'b1;
                end else if (accept_s) begin
                    x0_d       = cmd_x0;
                    x1_d       = cmd_x1;
                    y1_d       = cmd_y1;
                    color_d    = cmd_color;
                    cur_x_d    = cmd_x0;
                    cur_y_d    = cmd_y0;
                    row_base_d = mul_hres(cmd_y0);
                    state_d    = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                // A stalled cycle leaves the walk position untouched.
                if (write_s && last_s) begin
                    state_d = ST_DONE;
                end else if (write_s && (cur_x_q != x1_q)) begin
                    cur_x_d = cur_x_q + 10'd1;
                end else if (write_s) begin
                    cur_x_d    = x0_q;
                    cur_y_d    = cur_y_q + 10'd1;
                    row_base_d = row_base_q + H_STRIDE;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset wins over acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            x0_q       <= 10'd0;
            x1_q       <= 10'd0;
            y1_q       <= 10'd0;
            color_q    <= 9'd0;
            cur_x_q    <= 10'd0;
            cur_y_q    <= 10'd0;
            row_base_q <= 19'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            color_q    <= color_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            row_base_q <= row_base_d;
            err_q      <= err_d;
        end
    end

    // Memory port mux: display has absolute priority, fill uses idle slots.
    // Status outputs are held low while reset is asserted.
    always_comb begin
        cmd_ready  = cmd_ready_s;
        disp_grant = disp_req;
        mem_we     = write_s;
        mem_wdata  = color_q;
        if ((state_q == ST_FILL) && !disp_req) begin
            mem_addr = row_base_q + 19'(cur_x_q);
        end else begin
            mem_addr = disp_addr;
        end
        busy = (state_q != ST_IDLE) && !reset;
        done = (state_q == ST_DONE) && !reset;
        err  = err_q && !reset;
    end

endmodule

// File: tb/tb_fb_rect_fill_ctrl.sv
// Self-checking bench for fb_rect_fill_ctrl: directed corner cases plus
// randomized rectangles with random display interference, checked against
// a raster-order address list computed from y*640+x.
module tb_fb_rect_fill_ctrl;

    localparam int H = 640;
    localparam int V = 480;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [8:0]  cmd_color;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic        disp_grant;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [8:0]  mem_wdata;
    logic        busy, done, err;

    int checks;
    int errors;

    fb_rect_fill_ctrl #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color), .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_grant(disp_grant), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input int x0, input int y0, input int x1, input int y1, input int col);
        cmd_x0    = 10'(x0);
        cmd_y0    = 10'(y0);
        cmd_x1    = 10'(x1);
        cmd_y1    = 10'(y1);
        cmd_color = 9'(col);
    endtask

    // Present a command in IDLE and check it is offered cmd_ready.
    task automatic accept_cmd(input string name, input int x0, input int y0,
                              input int x1, input int y1, input int col);
        drive_cmd(x0, y0, x1, y1, col);
        cmd_valid = 1'b1;
        disp_req  = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready: cmd_ready=%b busy=%b required cmd_ready=1 busy=0", name, cmd_ready, busy);
        end
        next_cycle();
        cmd_valid = 1'b0;
        drive_cmd($urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 511));
    endtask

    // mode 0: no display traffic, 1: random display traffic,
    // 2: display holds the port for 3 cycles after the second write.
    // stop_after > 0 aborts the walk after that many writes (reset test).
    task automatic run_fill(input string name, input int x0, input int y0, input int x1,
                            input int y1, input int col, input int mode, input int stop_after);
        int exp_q[$];
        int idx;
        int stalls;
        int cyc;
        int n;
        logic dr;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                exp_q.push_back(y * H + x);
            end
        end
        n = (stop_after > 0) ? stop_after : exp_q.size();
        accept_cmd(name, x0, y0, x1, y1, col);
        idx = 0; stalls = 0; cyc = 0;
        while (idx < n && cyc < 2000) begin
            case (mode)
                1:       dr = ($urandom_range(0, 3) == 0);
                2:       dr = (idx == 2 && stalls < 3);
                default: dr = 1'b0;
            endcase
            disp_req  = dr;
            disp_addr = (mode == 2) ? 19'h12345 : 19'($urandom_range(0, 307199));
            @(negedge clk);
            checks++;
            if (dr) begin
                if (mem_we !== 1'b0 || mem_addr !== disp_addr || disp_grant !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_stall: we=%b addr=%h grant=%b done=%b required we=0 addr=%h grant=1 done=0",
                             name, mem_we, mem_addr, disp_grant, done, disp_addr);
                end
                stalls++;
            end else begin
                if (mem_we !== 1'b1 || mem_addr !== 19'(exp_q[idx]) || mem_wdata !== 9'(col) ||
                    disp_grant !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_write%0d: we=%b addr=%0d data=%h grant=%b done=%b busy=%b rdy=%b required we=1 addr=%0d data=%h grant=0 done=0 busy=1 rdy=0",
                             name, idx, mem_we, mem_addr, mem_wdata, disp_grant, done, busy, cmd_ready,
                             exp_q[idx], 9'(col));
                end
                idx++;
            end
            next_cycle();
            cyc++;
        end
        disp_req = 1'b0;
        if (idx < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: writes=%0d required %0d", name, idx, n);
        end
        if (mode == 2) begin
            checks++;
            if (stalls !== 3) begin
                errors++;
                $display("FAIL %s_stall_count: stalls=%0d required 3", name, stalls);
            end
        end
        if (stop_after == 0) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_done: done=%b busy=%b we=%b rdy=%b required done=1 busy=1 we=0 rdy=0",
                         name, done, busy, mem_we, cmd_ready);
            end
            next_cycle();
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL %s_idle: done=%b busy=%b rdy=%b we=%b required done=0 busy=0 rdy=1 we=0",
                         name, done, busy, cmd_ready, mem_we);
            end
            next_cycle();
        end
    endtask

    task automatic reject_cmd(input string name, input int x0, input int y0, input int x1, input int y1);
        accept_cmd(name, x0, y0, x1, y1, 9'h1AA);
        for (int c = 0; c < 3; c++) begin
            disp_req = 1'b0;
            @(negedge clk);
            checks++;
            if (err !== (c == 0) || mem_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_err%0d: err=%b we=%b busy=%b rdy=%b required err=%0d we=0 busy=0 rdy=1",
                         name, c, err, mem_we, busy, cmd_ready, (c == 0));
            end
            next_cycle();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_cmd(1, 1, 2, 2, 9'h055);
        cmd_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b busy=%b done=%b err=%b we=%b required all 0",
                     cmd_ready, busy, done, err, mem_we);
        end
        next_cycle();
        reset = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_priority: busy=%b we=%b rdy=%b required busy=0 we=0 rdy=1", busy, mem_we, cmd_ready);
        end
        next_cycle();
    endtask

    task automatic test_single_pixel();
        run_fill("single", 5, 3, 5, 3, 9'h1FF, 0, 0);
    endtask

    task automatic test_edge_rect();
        run_fill("edge", 638, 0, 639, 1, 9'h0C3, 0, 0);
        run_fill("last_pixel", 639, 479, 639, 479, 9'h101, 0, 0);
    endtask

    task automatic test_disp_stall();
        run_fill("stall", 20, 7, 23, 7, 9'h0F0, 2, 0);
    endtask

    task automatic test_reject();
        reject_cmd("rej_x1", 0, 0, 640, 0);
        reject_cmd("rej_xswap", 10, 0, 9, 0);
        reject_cmd("rej_y1", 0, 0, 0, 480);
        reject_cmd("rej_yswap", 0, 5, 0, 4);
    endtask

    task automatic test_reset_mid_fill();
        run_fill("abort", 100, 50, 109, 59, 9'h02A, 0, 5);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet%0d: we=%b done=%b busy=%b required we=0 done=0 busy=0",
                         c, mem_we, done, busy);
            end
            next_cycle();
            reset = 1'b0;
        end
        run_fill("after_abort", 7, 9, 7, 9, 9'h133, 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            int w, h, x0, y0;
            w  = $urandom_range(1, 6);
            h  = $urandom_range(1, 4);
            x0 = $urandom_range(0, H - w);
            y0 = $urandom_range(0, V - h);
            run_fill("rand", x0, y0, x0 + w - 1, y0 + h - 1, $urandom_range(0, 511), 1, 0);
            if ($urandom_range(0, 2) == 0) begin
                x0 = $urandom_range(1, 639);
                reject_cmd("rand_rej", x0, 0, x0 - 1, 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_fill("b2b_a", 0, 0, 2, 0, 9'h007, 0, 0);
        run_fill("b2b_b", 3, 0, 3, 1, 9'h038, 1, 0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        disp_req  = 1'b0;
        disp_addr = 19'd0;
        drive_cmd(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_pixel();
        test_edge_rect();
        test_disp_stall();
        test_reject();
        test_reset_mid_fill();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_rect_fill_ctrl.md
FB_RECT_FILL_CTRL -- requirements
Module: fb_rect_fill_ctrl

Interface
REQ-001 Parameter H_RES, default 640, framebuffer line width in pixels (address stride).
REQ-002 Parameter V_RES, default 480, framebuffer line count.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  fill command present.
REQ-007 cmd_ready  output  1  block accepts a command this cycle.
REQ-008 cmd_x0, cmd_y0, cmd_x1, cmd_y1  input  10 each  inclusive rectangle corners.
REQ-009 cmd_color  input  9  fill colour, packed as R[8:6] G[5:3] B[2:0].
REQ-010 disp_req  input  1  display scan-out needs the framebuffer this cycle.
REQ-011 disp_addr  input  19  display read address.
REQ-012 disp_grant  output  1  framebuffer port given to the display this cycle.
REQ-013 mem_addr  output  19  framebuffer address.
REQ-014 mem_we  output  1  framebuffer write enable.
REQ-015 mem_wdata  output  9  framebuffer write data.
REQ-016 busy  output  1  high while in FILL or DONE.
REQ-017 done  output  1  one-cycle pulse at fill completion.
REQ-018 err  output  1  one-cycle pulse on rejected command.

Function
REQ-019 The block SHALL implement states IDLE, FILL and DONE.
REQ-020 cmd_ready SHALL be 1 only in IDLE with reset low; acceptance is cmd_valid && cmd_ready.
REQ-021 On acceptance, it SHALL reject the command (err=1 next cycle, stay IDLE, no writes) if x0>x1, y0>y1, x1>=H_RES or y1>=V_RES.
REQ-022 On valid acceptance, it SHALL latch x0, x1, y1 and colour, set cur_x=x0, cur_y=y0, row_base=y0*H_RES computed by shift-add (no multiplier; for 640 use (y0<<9)+(y0<<7)), and enter FILL.
REQ-023 Display SHALL have absolute priority: in every state, when disp_req=1, mem_addr=disp_addr, mem_we=0 and disp_grant=1.
REQ-024 In FILL with disp_req=0: mem_we=1, mem_addr=row_base+cur_x (19-bit, no overflow up to 307199), mem_wdata=colour, disp_grant=0.
REQ-025 A FILL cycle with disp_req=1 SHALL stall, with cur_x, cur_y and row_base held and the same pixel written on the next free cycle.
REQ-026 After each write: if cur_x!=x1 then cur_x+1; else cur_x=x0, cur_y+1, row_base+H_RES; when cur_x==x1 and cur_y==y1, the next state SHALL be DONE.
REQ-027 Writes SHALL occur in raster order, exactly (x1-x0+1)*(y1-y0+1) per command, with no address written twice.
REQ-028 Outside FILL, or when disp_req=0 outside FILL: mem_we=0, mem_addr=disp_addr, disp_grant=disp_req.
REQ-029 DONE SHALL last one cycle with done=1 and then return to IDLE; cmd_ready goes high the cycle after DONE.
REQ-030 Latency: first write SHALL occur the cycle after acceptance if disp_req=0; done SHALL be asserted the cycle after the last write.
REQ-031 mem_* and disp_grant SHALL be combinational from the current state and registers; all other state SHALL be registered.

Reset
REQ-032 On reset: state=IDLE; done=0, err=0, busy=0, mem_we=0, cmd_ready=0 during reset; cur_x, cur_y, row_base=0.
REQ-033 Reset mid-FILL SHALL abort the command with no further writes and no done pulse; the next command is accepted normally.
REQ-034 Reset SHALL take priority over command acceptance in the same cycle.

Verification
REQ-035 Single pixel (5,3)-(5,3), colour 0x1FF, disp_req=0 -> one write, addr 1925, data 0x1FF, done one cycle later, then cmd_ready=1.
REQ-036 Rect (638,0)-(639,1) -> writes at addrs 638, 639, 1278, 1279 on consecutive cycles, then done.
REQ-037 During a 4x1 fill, disp_req=1 for 3 cycles after the second write with disp_addr=0x12345 -> mem_addr=0x12345, mem_we=0, disp_grant=1 for those 3 cycles; the third pixel is written next, 4 writes total.
REQ-038 cmd_x1=640 (or x0=10, x1=9) -> err pulse, zero writes, stays IDLE, cmd_ready=1.
REQ-039 Full screen (0,0)-(639,479) -> 307200 writes, last addr 307199, single done pulse.
REQ-040 Reset after 5 writes of a 10x10 fill -> mem_we=0 from the next cycle, no done pulse; a new 1x1 command then completes normally.
